regfile_wb_sequencer: RTL and testbench
=======================================

Name: regfile_wb_sequencer

Overview:
- Multicycle sequencer for the MIPS CPU.
- Steps each instruction through FETCH/DECODE/EXECUTE/MEMORY_ACCESS/WRITE_BACK.
- Latches the fetched instruction into an internal IR.
- Owns the register-file write port: generates RegWrite, the destination index writeR and the write-back source select.
- Sits between the memory interface, the datapath muxes and the register file; its state output feeds the register file and ALU control.

Parameters:
- LINK_REG, 31, destination index for JAL/BGEZAL/BLTZAL link writes.

Ports:
- clk  input  1  system clock, all state on rising edge
- reset  input  1  asynchronous, active-high; clears FSM, IR and outputs immediately
- waitrequest  input  1  memory busy; stalls FETCH and MEMORY_ACCESS
- instr_rdata  input  32  instruction word from memory, valid in FETCH when waitrequest=0
- halt_req  input  1  PC reached halt address; sampled only in FETCH
- state  output  3  FETCH=000, DECODE=001, EXECUTE=010, MEMORY_ACCESS=011, WRITE_BACK=100, HALT=101
- instr  output  32  latched IR
- RegWrite  output  1  register-file write enable
- writeR  output  5  register-file write index
- wb_sel  output  2  write-data source: 00 ALU, 01 memory read data, 10 link (PC+8)
- active  output  1  high unless in HALT

Behaviour:
- Reset (async): state=FETCH, instr=0, active=1, RegWrite=0, writeR=0, wb_sel=00. Reset asserted mid-instruction aborts it; no register write occurs.
- Decode is combinational from the IR:
  - R-type (opcode 000000) writes rd (instr[15:11]), wb_sel=00. Exceptions: JR (funct 001000), MTHI/MTLO (010001/010011) and MULT/MULTU/DIV/DIVU (011000-011011) write nothing.
  - JALR (funct 001001) writes rd with wb_sel=10.
  - I-type ALU ops (opcodes 001001-001111) write rt (instr[20:16]), wb_sel=00.
  - Loads (opcodes 100000-100110) write rt, wb_sel=01, and need memory.
  - Stores (101000, 101001, 101011) need memory and write nothing.
  - JAL (000011) and REGIMM (000001) with rt=10000 or 10001 write LINK_REG, wb_sel=10, regardless of branch outcome.
  - All other opcodes write nothing.
- FSM transitions:
  - FETCH: if halt_req=1, go to HALT. Else if waitrequest=1, stay. Else latch instr_rdata into IR and go to DECODE.
  - DECODE -> EXECUTE unconditionally.
  - EXECUTE: load/store -> MEMORY_ACCESS; else instruction writes a register -> WRITE_BACK; else -> FETCH.
  - MEMORY_ACCESS: stay while waitrequest=1. Otherwise load -> WRITE_BACK, store -> FETCH.
  - WRITE_BACK -> FETCH.
  - HALT: absorbing until reset. halt_req takes priority over waitrequest in FETCH.
- Write port rules:
  - RegWrite is combinational and high only in WRITE_BACK, for exactly one cycle per writing instruction, and only when the destination index is non-zero. Writes to $0 are suppressed, so $zero stays 0.
  - writeR and wb_sel are combinational from the IR in every state and are don't-care outside WRITE_BACK. The bench checks them only when RegWrite=1.
  - The IR is held constant from DECODE through WRITE_BACK; waitrequest has no effect in DECODE, EXECUTE or WRITE_BACK.
- Latency (no stalls): ALU op 4 cycles; load 5; store 4; non-writing op 3. Each waitrequest cycle adds one.

Test Plan:
- ADDIU $3,$0,5 (0x24030005), waitrequest=0 -> states 000,001,010,100,000; RegWrite=1 for one cycle with writeR=3, wb_sel=00.
- LW $4,0($1) (0x8C240000), waitrequest=1 for 2 cycles in MEMORY_ACCESS -> MEMORY_ACCESS held 3 cycles, then WRITE_BACK with writeR=4, wb_sel=01.
- JAL 0x0000010 (0x0C000004) -> writeR=31, wb_sel=10. BLTZAL $5 (0x04B00002) -> writeR=31, wb_sel=10.
- SW (0xAC240000) and JR $31 (0x03E00008) -> RegWrite never asserts. ADDU $0,$1,$2 (0x00220021) -> reaches WRITE_BACK, RegWrite=0.
- halt_req=1 in FETCH while waitrequest=1 -> state=101, active=0, remains there for 20 cycles.
- Assert reset asynchronously mid-EXECUTE of an ALU op -> state=000 and instr=0 before the next edge; no RegWrite pulse.

Source files
------------

// File: rtl/regfile_wb_sequencer.sv
// Multicycle FETCH/DECODE/EXECUTE/MEMORY_ACCESS/WRITE_BACK sequencer for the MIPS core.
// Holds the instruction register and drives the register-file write port.
module regfile_wb_sequencer #(
  parameter logic [4:0] LINK_REG = 5'd31
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        waitrequest,
  input  logic [31:0] instr_rdata,
  input  logic        halt_req,
  output logic [2:0]  state,
  output logic [31:0] instr,
  output logic        RegWrite,
  output logic [4:0]  writeR,
  output logic [1:0]  wb_sel,
  output logic        active
);

  typedef enum logic [2:0] {
    ST_FETCH      = 3'b000,
    ST_DECODE     = 3'b001,
    ST_EXECUTE    = 3'b010,
    ST_MEM_ACCESS = 3'b011,
    ST_WRITE_BACK = 3'b100,
    ST_HALT       = 3'b101
  } state_t;

  localparam logic [1:0] WB_ALU  = 2'b00;
  localparam logic [1:0] WB_MEM  = 2'b01;
  localparam logic [1:0] WB_LINK = 2'b10;

  localparam logic [5:0] OP_SPECIAL = 6'b000000;
  localparam logic [5:0] OP_REGIMM  = 6'b000001;
  localparam logic [5:0] OP_JAL     = 6'b000011;

  state_t      state_reg;
  logic [31:0] instr_reg;
  logic        active_reg;

  logic [5:0] opcode;
  logic [5:0] funct;
  logic [4:0] rt_field;
  logic [4:0] rd_field;

  logic       dec_writes;
  logic [4:0] dec_dest;
  logic [1:0] dec_wb_sel;
  logic       dec_mem;
  logic       dec_load;

  assign opcode   = instr_reg[31:26];
  assign funct    = instr_reg[5:0];
  assign rt_field = instr_reg[20:16];
  assign rd_field = instr_reg[15:11];

  // Instruction class decode; everything downstream is derived from the held IR.
  always_comb begin
    dec_writes = 1'b0;
    dec_dest   = 5'd0;
    dec_wb_sel = WB_ALU;
    dec_mem    = 1'b0;
    dec_load   = 1'b0;
    case (opcode)
      OP_SPECIAL: begin
        case (funct)
          6'b001000, 6'b010001, 6'b010011,
          6'b011000, 6'b011001, 6'b011010, 6'b011011: begin
            dec_writes = 1'b0;
          end
          6'b001001: begin
            dec_writes = 1'b1;
            dec_dest   = rd_field;
            dec_wb_sel = WB_LINK;
          end
          default: begin
            dec_writes = 1'b1;
            dec_dest   = rd_field;
            dec_wb_sel = WB_ALU;
          end
        endcase
      end
      OP_REGIMM: begin
        // Link variants write $ra whether or not the branch is taken.
        if (rt_field == 5'b10000 || rt_field == 5'b10001) begin
          dec_writes = 1'b1;
          dec_dest   = LINK_REG;
          dec_wb_sel = WB_LINK;
        end
      end
      OP_JAL: begin
        dec_writes = 1'b1;
        dec_dest   = LINK_REG;
        dec_wb_sel = WB_LINK;
      end
      6'b001001, 6'b001010, 6'b001011, 6'b001100,
      6'b001101, 6'b001110, 6'b001111: begin
        dec_writes = 1'b1;
        dec_dest   = rt_field;
        dec_wb_sel = WB_ALU;
      end
      6'b100000, 6'b100001, 6'b100010, 6'b100011,
      6'b100100, 6'b100101, 6'b100110: begin
        dec_writes = 1'b1;
        dec_dest   = rt_field;
        dec_wb_sel = WB_MEM;
        dec_mem    = 1'b1;
        dec_load   = 1'b1;
      end
      6'b101000, 6'b101001, 6'b101011: begin
        dec_mem = 1'b1;
      end
      default: begin
        dec_writes = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg  <= ST_FETCH;
      instr_reg  <= 32'd0;
      active_reg <= 1'b1;
    end else begin
      case (state_reg)
        ST_FETCH: begin
          // halt_req wins over a stalled fetch.
          if (halt_req) begin
            state_reg  <= ST_HALT;
            active_reg <= 1'b0;
          end else if (!waitrequest) begin
            instr_reg <= instr_rdata;
            state_reg <= ST_DECODE;
          end
        end
        ST_DECODE: begin
          state_reg <= ST_EXECUTE;
        end
        ST_EXECUTE: begin
          if (dec_mem) begin
            state_reg <= ST_MEM_ACCESS;
          end else if (dec_writes) begin
            state_reg <= ST_WRITE_BACK;
          end else begin
            state_reg <= ST_FETCH;
          end
        end
        ST_MEM_ACCESS: begin
          if (!waitrequest) begin
            state_reg <= dec_load ? ST_WRITE_BACK : ST_FETCH;
          end
        end
        ST_WRITE_BACK: begin
          state_reg <= ST_FETCH;
        end
        ST_HALT: begin
          state_reg  <= ST_HALT;
          active_reg <= 1'b0;
        end
        default: begin
          state_reg <= ST_FETCH;
        end
      endcase
    end
  end

  assign state    = state_reg;
  assign instr    = instr_reg;
  assign active   = active_reg;
  assign writeR   = dec_dest;
  assign wb_sel   = dec_wb_sel;
  // Writes to $zero are dropped so the register stays hard-wired to 0.
  assign RegWrite = (state_reg == ST_WRITE_BACK) && dec_writes && (dec_dest != 5'd0);

endmodule

// File: tb/tb_regfile_wb_sequencer.sv
// Scoreboard bench for regfile_wb_sequencer: random instructions and stalls,
// expected state trace and register writes come from an instruction-level model.
module tb_regfile_wb_sequencer;

  localparam logic [2:0] S_FETCH = 3'b000;
  localparam logic [2:0] S_DEC   = 3'b001;
  localparam logic [2:0] S_EXE   = 3'b010;
  localparam logic [2:0] S_MEM   = 3'b011;
  localparam logic [2:0] S_WB    = 3'b100;
  localparam logic [2:0] S_HALT  = 3'b101;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        waitrequest = 1'b0;
  logic [31:0] instr_rdata = 32'd0;
  logic        halt_req = 1'b0;
  logic [2:0]  state;
  logic [31:0] instr;
  logic        RegWrite;
  logic [4:0]  writeR;
  logic [1:0]  wb_sel;
  logic        active;

  regfile_wb_sequencer #(.LINK_REG(5'd31)) dut (
    .clk(clk), .reset(reset), .waitrequest(waitrequest), .instr_rdata(instr_rdata),
    .halt_req(halt_req), .state(state), .instr(instr), .RegWrite(RegWrite),
    .writeR(writeR), .wb_sel(wb_sel), .active(active)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  st;
    logic [31:0] ir;
    logic        rw;
    logic        act;
  } cyc_t;

  typedef struct {
    logic [4:0] dest;
    logic [1:0] wb;
  } wr_t;

  typedef struct {
    bit       writes;
    bit [4:0] dest;
    bit [1:0] wb;
    bit       mem;
    bit       load;
  } ref_t;

  cyc_t        exp_q[$];
  wr_t         wr_q[$];
  int          n_checks = 0;
  int          n_fail = 0;
  logic [31:0] prev_ir = 32'd0;

  // Instruction-level reference: which register an instruction targets and from where.
  function automatic ref_t ref_decode(input logic [31:0] w);
    ref_t r;
    int op, fn, rt, rd;
    op = int'(w[31:26]); fn = int'(w[5:0]); rt = int'(w[20:16]); rd = int'(w[15:11]);
    r = '{writes: 0, dest: 0, wb: 0, mem: 0, load: 0};
    if (op == 0) begin
      if (fn == 8 || fn == 17 || fn == 19 || (fn >= 24 && fn <= 27)) r.writes = 0;
      else begin
        r.writes = 1; r.dest = 5'(rd); r.wb = (fn == 9) ? 2 : 0;
      end
    end else if (op == 3 || (op == 1 && (rt == 16 || rt == 17))) begin
      r.writes = 1; r.dest = 31; r.wb = 2;
    end else if (op >= 9 && op <= 15) begin
      r.writes = 1; r.dest = 5'(rt); r.wb = 0;
    end else if (op >= 32 && op <= 38) begin
      r.writes = 1; r.dest = 5'(rt); r.wb = 1; r.mem = 1; r.load = 1;
    end else if (op == 40 || op == 41 || op == 43) begin
      r.mem = 1;
    end
    return r;
  endfunction

  task automatic step(input logic rst, input logic wr, input logic hq, input logic [31:0] rd,
                      input logic [2:0] es, input logic [31:0] ei, input logic erw);
    cyc_t c;
    @(posedge clk); #1;
    reset = rst; waitrequest = wr; halt_req = hq; instr_rdata = rd;
    c.st = es; c.ir = ei; c.rw = erw; c.act = (es != S_HALT);
    exp_q.push_back(c);
  endtask

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic run_instr(input logic [31:0] w, input int fstall, input int mstall);
    ref_t  r;
    wr_t   wi;
    logic  rw;
    r = ref_decode(w);
    for (int i = 0; i < fstall; i++) step(0, 1, 0, $urandom, S_FETCH, prev_ir, 0);
    step(0, 0, 0, w, S_FETCH, prev_ir, 0);
    prev_ir = w;
    step(0, rbit(), rbit(), $urandom, S_DEC, w, 0);
    step(0, rbit(), rbit(), $urandom, S_EXE, w, 0);
    if (r.mem) begin
      for (int i = 0; i < mstall; i++) step(0, 1, rbit(), $urandom, S_MEM, w, 0);
      step(0, 0, rbit(), $urandom, S_MEM, w, 0);
    end
    if (r.load || (!r.mem && r.writes)) begin
      rw = r.writes && (r.dest != 0);
      if (rw) begin
        wi.dest = r.dest; wi.wb = r.wb;
        wr_q.push_back(wi);
      end
      step(0, rbit(), rbit(), $urandom, S_WB, w, rw);
    end
  endtask

  function automatic logic [31:0] gen_instr();
    logic [31:0] w;
    logic [5:0]  fl [12];
    logic [4:0]  rl [4];
    int          sel;
    fl = '{6'h08, 6'h09, 6'h11, 6'h13, 6'h18, 6'h19, 6'h1A, 6'h1B, 6'h20, 6'h21, 6'h2A, 6'h10};
    rl = '{5'h10, 5'h11, 5'h00, 5'h01};
    w = $urandom;
    sel = $urandom_range(0, 9);
    case (sel)
      2, 3: begin w[31:26] = 6'd0; w[5:0] = fl[$urandom_range(0, 11)]; end
      4: begin w[31:26] = 6'd1; w[20:16] = rl[$urandom_range(0, 3)]; end
      5: w[31:26] = 6'd3;
      6: w[31:26] = 6'($urandom_range(9, 15));
      7: w[31:26] = 6'($urandom_range(32, 38));
      8: w[31:26] = ($urandom_range(0, 2) == 0) ? 6'd40 : (($urandom_range(0, 1) == 0) ? 6'd41 : 6'd43);
      9: w[31:26] = 6'd8;
      default: ;
    endcase
    if ($urandom_range(0, 7) == 0) begin w[20:16] = 5'd0; w[15:11] = 5'd0; end
    return w;
  endfunction

  // Monitor: compares every cycle's observed outputs against the queued expectation.
  initial begin
    cyc_t c;
    wr_t  wi;
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        c = exp_q.pop_front();
        n_checks++;
        if (state !== c.st) begin
          n_fail++; $display("FAIL state: got %b expected %b at %0t", state, c.st, $time);
        end
        n_checks++;
        if (instr !== c.ir) begin
          n_fail++; $display("FAIL instr: got %h expected %h at %0t", instr, c.ir, $time);
        end
        n_checks++;
        if (RegWrite !== c.rw) begin
          n_fail++; $display("FAIL regwrite: got %b expected %b at %0t", RegWrite, c.rw, $time);
        end
        n_checks++;
        if (active !== c.act) begin
          n_fail++; $display("FAIL active: got %b expected %b at %0t", active, c.act, $time);
        end
      end
      if (RegWrite === 1'b1) begin
        n_checks++;
        if (wr_q.size() == 0) begin
          n_fail++; $display("FAIL write_unexpected: got writeR=%0d wb_sel=%b expected no write at %0t", writeR, wb_sel, $time);
        end else begin
          wi = wr_q.pop_front();
          if (writeR !== wi.dest || wb_sel !== wi.wb) begin
            n_fail++;
            $display("FAIL write_port: got writeR=%0d wb_sel=%b expected writeR=%0d wb_sel=%b at %0t",
                     writeR, wb_sel, wi.dest, wi.wb, $time);
          end else begin
            $display("write ok: writeR=%0d wb_sel=%b instr=%h", writeR, wb_sel, instr);
          end
        end
      end
    end
  end

  initial begin
    cyc_t c;
    step(1, 0, 0, 32'd0, S_FETCH, 32'd0, 0);
    step(1, 0, 0, 32'd0, S_FETCH, 32'd0, 0);

    run_instr(32'h24030005, 0, 0);   // ADDIU $3,$0,5
    run_instr(32'h8C240000, 1, 2);   // LW $4,0($1)
    run_instr(32'h0C000004, 0, 0);   // JAL
    run_instr(32'h04B00002, 2, 0);   // BLTZAL $5
    run_instr(32'hAC240000, 0, 3);   // SW
    run_instr(32'h03E00008, 0, 0);   // JR $31
    run_instr(32'h00220021, 0, 0);   // ADDU $0,$1,$2

    for (int n = 0; n < 150; n++)
      run_instr(gen_instr(), $urandom_range(0, 3), $urandom_range(0, 3));

    // Abort an ADDIU with an asynchronous reset in the middle of EXECUTE.
    step(0, 0, 0, 32'h24030005, S_FETCH, prev_ir, 0);
    step(0, 0, 0, 32'd0, S_DEC, 32'h24030005, 0);
    @(posedge clk); #1;
    c.st = S_FETCH; c.ir = 32'd0; c.rw = 0; c.act = 1;
    exp_q.push_back(c);
    #2 reset = 1'b1;
    step(1, 0, 0, 32'd0, S_FETCH, 32'd0, 0);
    prev_ir = 32'd0;
    run_instr(32'h24030005, 0, 0);

    // Halt requested while memory is busy; HALT must absorb everything afterwards.
    step(0, 1, 1, $urandom, S_FETCH, prev_ir, 0);
    for (int i = 0; i < 20; i++) step(0, rbit(), rbit(), $urandom, S_HALT, prev_ir, 0);

    @(negedge clk); #1;
    n_checks++;
    if (exp_q.size() != 0 || wr_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d cycles and %0d writes pending expected 0 and 0", exp_q.size(), wr_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
